// File: rtl/ifetch_resp.sv
// ifetch_resp: in-order instruction fetch request/response adapter between the IF stage and the memory side.
// Optional one-entry reuse buffer for back-to-back refetch of the same cacheable word, enabled by IFETCH_REUSE_EN.
module ifetch_resp #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cacheable,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  output logic        rd_cacheable,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic [31:0] ret_data
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] r_cnt;
  logic          r_data_ok;
  logic [31:0]   r_rdata;
  logic          w_hit, w_acc, w_ret, w_full;
  logic [31:0]   w_hit_data;
  assign w_full       = (r_cnt == CW'(DEPTH));
  assign w_ret        = ret_valid & (r_cnt != '0);
  // Gated by resetn so nothing is offered or acknowledged while held in reset.
  assign rd_req       = resetn & inst_req & ~w_full & ~w_hit;
  assign w_acc        = rd_req & rd_rdy;
  assign addr_ok      = w_acc | (resetn & inst_req & w_hit);
  assign rd_addr      = inst_addr;
  assign rd_cacheable = inst_cacheable;
  assign data_ok      = r_data_ok;
  assign rdata        = r_rdata;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_cnt <= '0;
    else if (w_acc & ~w_ret) r_cnt <= r_cnt + 1'b1;
    else if (w_ret & ~w_acc) r_cnt <= r_cnt - 1'b1;
  // A memory return and a reuse hit are exclusive: a hit needs cnt == 0, a counted return needs cnt != 0.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_data_ok <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_data_ok <= w_ret | w_hit;
      r_rdata   <= w_ret ? ret_data : w_hit ? w_hit_data : r_rdata;
    end
`ifdef IFETCH_REUSE_EN
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [31:0]   r_aq [DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic          r_buf_v;
  logic [31:0]   r_buf_a, r_buf_d, r_daddr;
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  // A cycle with data_ok high is still writing the buffer, so it cannot serve a hit yet.
  assign w_hit      = r_buf_v & (r_buf_a == inst_addr) & inst_cacheable & (r_cnt == '0) & ~r_data_ok;
  assign w_hit_data = r_buf_d;
  always_ff @(posedge clk)
    if (w_acc) r_aq[r_wp] <= inst_addr;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_buf_v <= 1'b0;
      r_buf_a <= '0;
      r_buf_d <= '0;
      r_daddr <= '0;
    end else begin
      if (w_acc) r_wp <= ptr_inc(r_wp);
      if (w_ret) r_rp <= ptr_inc(r_rp);
      if (w_ret | w_hit) r_daddr <= w_ret ? r_aq[r_rp] : inst_addr;
      if (r_data_ok) begin
        r_buf_v <= 1'b1;
        r_buf_a <= r_daddr;
        r_buf_d <= r_rdata;
      end
    end
`else
  assign w_hit      = 1'b0;
  assign w_hit_data = '0;
`endif
endmodule

// File: tb/tb_ifetch_resp.sv
// tb_ifetch_resp: directed self-checking bench for ifetch_resp (DEPTH=2) with a return-data scoreboard.
// Covers reset, single fetch, full stall, stray return, mid-operation reset and reuse (IFETCH_REUSE_EN aware).
module tb_ifetch_resp;
  localparam int DEPTH = 2;
  logic        clk = 1'b0, resetn = 1'b1;
  logic        inst_req = 1'b0, inst_cacheable = 1'b0, rd_rdy = 1'b0, ret_valid = 1'b0;
  logic [31:0] inst_addr = '0, ret_data = '0;
  logic        addr_ok, data_ok, rd_req, rd_cacheable;
  logic [31:0] rdata, rd_addr;
  int          checks = 0, errors = 0;
  int          m_cnt = 0;
  logic        m_dok = 1'b0, m_bv = 1'b0;
  logic [31:0] m_rdata = '0, m_ba = '0, m_bd = '0, m_last_a = '0;
  logic [31:0] exp_q [$];
  logic [31:0] addr_q [$];
  logic [31:0] dok_addr_q [$];

  always #5 clk = ~clk;

  ifetch_resp #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_cacheable(inst_cacheable), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_cacheable(rd_cacheable), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0; inst_req = 1'b1; inst_addr = 32'h1C00_0000; inst_cacheable = 1'b1;
    rd_rdy = 1'b1; ret_valid = 1'b1; ret_data = 32'hFFFF_FFFF;
    #1;
    chk("rst.addr_ok", 32'(addr_ok), 32'd0);
    chk("rst.rd_req", 32'(rd_req), 32'd0);
    chk("rst.data_ok", 32'(data_ok), 32'd0);
    chk("rst.rdata", rdata, 32'h0);
    m_cnt = 0; m_dok = 1'b0; m_rdata = '0; m_bv = 1'b0;
    exp_q.delete(); addr_q.delete(); dok_addr_q.delete();
    @(posedge clk); #1;
    chk("rst.hold.data_ok", 32'(data_ok), 32'd0);
    chk("rst.hold.rdata", rdata, 32'h0);
    inst_req = 1'b0; ret_valid = 1'b0; resetn = 1'b1;
    #1;
  endtask

  task automatic step(input string tag, input logic req, input logic [31:0] a, input logic c,
                      input logic rdy, input logic rv, input logic [31:0] d);
    logic hit, exp_rd, exp_ok, acc, ret;
    inst_req = req; inst_addr = a; inst_cacheable = c; rd_rdy = rdy; ret_valid = rv; ret_data = d;
    #1;
    hit = 1'b0;
`ifdef IFETCH_REUSE_EN
    hit = m_bv && (m_ba == a) && c && (m_cnt == 0) && !m_dok;
`endif
    exp_rd = resetn && req && (m_cnt < DEPTH) && !hit;
    acc    = exp_rd && rdy;
    exp_ok = acc || (resetn && req && hit);
    ret    = rv && (m_cnt > 0);
    chk({tag, ".rd_req"}, 32'(rd_req), 32'(exp_rd));
    chk({tag, ".addr_ok"}, 32'(addr_ok), 32'(exp_ok));
    chk({tag, ".rd_addr"}, rd_addr, a);
    chk({tag, ".rd_cacheable"}, 32'(rd_cacheable), 32'(c));
    if (acc) addr_q.push_back(a);
    if (ret) begin
      exp_q.push_back(d);
      dok_addr_q.push_back(addr_q.pop_front());
    end else if (hit) begin
      exp_q.push_back(m_bd);
      dok_addr_q.push_back(a);
    end
    m_cnt = m_cnt + int'(acc) - int'(ret);
    if (m_dok) begin
      m_bv = 1'b1; m_ba = m_last_a; m_bd = m_rdata;
    end
    @(posedge clk); #1;
    m_dok = (exp_q.size() > 0);
    if (m_dok) begin
      m_rdata  = exp_q.pop_front();
      m_last_a = dok_addr_q.pop_front();
    end
    chk({tag, ".data_ok"}, 32'(data_ok), 32'(m_dok));
    chk({tag, ".rdata"}, rdata, m_rdata);
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    // single fetch
    step("single.req", 1, 32'h1C00_0000, 1, 1, 0, 0);
    step("single.ret", 0, 0, 0, 1, 1, 32'h0280_0000);
    step("single.idle", 0, 0, 0, 1, 0, 0);
    step("stray", 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    step("norady", 1, 32'h1C00_0000, 1, 0, 0, 0);
    // fill to DEPTH, stall, then accept with simultaneous return
    step("full.a0", 1, 32'h1C00_0000, 1, 1, 0, 0);
    step("full.a1", 1, 32'h1C00_0004, 1, 1, 0, 0);
    step("full.stall0", 1, 32'h1C00_0008, 1, 1, 0, 0);
    step("full.stall1", 1, 32'h1C00_0008, 1, 1, 0, 0);
    step("full.ret0", 1, 32'h1C00_0008, 1, 1, 1, 32'hA000_0000);
    step("full.a2", 1, 32'h1C00_0008, 1, 1, 0, 0);
    step("full.ret1", 0, 0, 0, 1, 1, 32'hA000_0001);
    step("full.accret", 1, 32'h1C00_000C, 0, 1, 1, 32'hA000_0002);
    step("full.a4", 1, 32'h1C00_0010, 1, 1, 0, 0);
    step("full.stall2", 1, 32'h1C00_0014, 1, 1, 0, 0);
    step("full.ret3", 0, 0, 0, 1, 1, 32'hA000_0003);
    step("full.ret4", 0, 0, 0, 1, 1, 32'hA000_0004);
    step("full.stray", 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    // reuse of the same cacheable word
    step("reuse.req", 1, 32'h1C00_0010, 1, 1, 0, 0);
    step("reuse.ret", 0, 0, 0, 1, 1, 32'h1234_5678);
    step("reuse.idle", 0, 0, 0, 1, 0, 0);
    step("reuse.hit", 1, 32'h1C00_0010, 1, 1, 0, 0);
    step("reuse.hitret", 0, 0, 0, 1, 1, 32'h5555_5555);
    step("reuse.idle2", 0, 0, 0, 1, 0, 0);
    step("reuse.uncached", 1, 32'h1C00_0010, 0, 1, 0, 0);
    step("reuse.ucret", 0, 0, 0, 1, 1, 32'h6666_6666);
    step("reuse.idle3", 0, 0, 0, 1, 0, 0);
    // reset with requests outstanding drops them and invalidates the buffer
    step("mid.a0", 1, 32'h1C00_0020, 1, 1, 0, 0);
    step("mid.a1", 1, 32'h1C00_0024, 1, 1, 0, 0);
    do_reset();
    step("mid.lateret", 0, 0, 0, 1, 1, 32'hBAD0_0001);
    step("mid.refetch", 1, 32'h1C00_0010, 1, 1, 0, 0);
    step("mid.ret", 0, 0, 0, 1, 1, 32'h7777_7777);
    step("mid.idle", 0, 0, 0, 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
